// File: rtl/reg_file_wb_pkg.sv
// Shared datapath constants and the ALU operation encoding used alongside the
// register file.
package Definitions;
  localparam int REG_W = 8;
  localparam int REG_A = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;
endpackage

// File: rtl/reg_file_wb.sv
// Register file with a one-entry writeback stage, read-side forwarding from
// that stage, and a registered ALU status-flag triple.
module reg_file_wb
  import Definitions::*;
#(
  parameter int W = REG_W,
  parameter int A = REG_A
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         WrEn,
  input  logic [A-1:0] WaddrIn,
  input  logic [W-1:0] DataIn,
  input  logic         ZeroIn,
  input  logic         ParityIn,
  input  logic         OddIn,
  input  logic         FlagWrEn,
  output logic         ZeroOut,
  output logic         ParityOut,
  output logic         OddOut,
  output logic         PendValid
);

  logic [W-1:0] r_regs [2**A];
  logic         r_pend_vld_p1;
  logic [A-1:0] r_pend_addr_p1;
  logic [W-1:0] r_pend_data_p1;
  logic [2:0]   r_flags;

  // Writeback stage: the held entry retires into the array on the same edge a
  // new one is captured, so back-to-back writes never stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 2**A; i++) r_regs[i] <= '0;
      r_pend_vld_p1  <= 1'b0;
      r_pend_addr_p1 <= '0;
      r_pend_data_p1 <= '0;
      r_flags        <= '0;
    end else begin
      if (r_pend_vld_p1) r_regs[r_pend_addr_p1] <= r_pend_data_p1;
      r_pend_vld_p1 <= WrEn;
      if (WrEn) begin
        r_pend_addr_p1 <= WaddrIn;
        r_pend_data_p1 <= DataIn;
      end
      if (FlagWrEn) r_flags <= {ZeroIn, ParityIn, OddIn};
    end
  end

  // Reads see the uncommitted entry first; DataIn itself is never bypassed.
  logic w_hit_a;
  logic w_hit_b;

  assign w_hit_a  = r_pend_vld_p1 && (RaddrA == r_pend_addr_p1);
  assign w_hit_b  = r_pend_vld_p1 && (RaddrB == r_pend_addr_p1);
  assign DataOutA = w_hit_a ? r_pend_data_p1 : r_regs[RaddrA];
  assign DataOutB = w_hit_b ? r_pend_data_p1 : r_regs[RaddrB];

  assign PendValid = r_pend_vld_p1;
  assign ZeroOut   = r_flags[2];
  assign ParityOut = r_flags[1];
  assign OddOut    = r_flags[0];

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 SHALL have parameter W, default 8, data width (matches ALU operand width).
REQ-002 SHALL have parameter A, default 3, register address width (2**A registers).
REQ-003 SHALL have port Clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports RaddrA, RaddrB  input  A  read addresses for ALU InputA / InputB.
REQ-006 SHALL have ports DataOutA, DataOutB  output  W  read data, driven to ALU InputA / InputB.
REQ-007 SHALL have port WrEn  input  1  request to write DataIn to WaddrIn.
REQ-008 SHALL have port WaddrIn  input  A  destination register.
REQ-009 SHALL have port DataIn  input  W  write data (ALU Out).
REQ-010 SHALL have ports ZeroIn, ParityIn, OddIn  input  1  ALU status flags.
REQ-011 SHALL have port FlagWrEn  input  1  latch the flag inputs.
REQ-012 SHALL have ports ZeroOut, ParityOut, OddOut  output  1  registered flags.
REQ-013 SHALL have port PendValid  output  1  writeback stage holds an uncommitted write.

Function
REQ-014 SHALL hold 2**A registers of W bits; all registers, R0 included, are writable.
REQ-015 SHALL implement a one-entry writeback stage: PendValid, PendAddr (A bits), PendData (W bits).
REQ-016 On a rising edge with WrEn=1, the stage SHALL capture WaddrIn/DataIn and set PendValid=1.
REQ-017 On a rising edge with PendValid=1, the array SHALL be written with PendData at PendAddr.
REQ-018 On a rising edge with WrEn=0, PendValid SHALL clear after the commit of REQ-017.
REQ-019 Back-to-back WrEn SHALL commit the old entry and capture the new one on the same edge, with no stall and no lost write.
REQ-020 Reads SHALL be combinational: if PendValid=1 and the read address equals PendAddr, output PendData; otherwise output the array entry.
REQ-021 Write-to-read latency SHALL be one edge: data presented with WrEn is readable in the following cycle.
REQ-022 Same-cycle WrEn and read of WaddrIn SHALL return the old value; there is no combinational DataIn bypass.
REQ-023 Back-to-back writes to the same address SHALL leave the later value in both the array and the read path.
REQ-024 Both read ports SHALL forward independently and may address the same register.
REQ-025 On a rising edge with FlagWrEn=1, all three flags SHALL update together; with FlagWrEn=0 they SHALL hold.
REQ-026 FlagWrEn SHALL be independent of WrEn, and any combination SHALL be legal.
REQ-027 Out-of-range addresses cannot occur because the array is exactly 2**A deep; there is no error output.

Reset
REQ-028 When Reset=1 at a rising edge, all registers SHALL become 0.
REQ-029 When Reset=1 at a rising edge, PendValid SHALL become 0.
REQ-030 When Reset=1 at a rising edge, ZeroOut, ParityOut and OddOut SHALL become 0.
REQ-031 Reset SHALL take priority over WrEn/FlagWrEn; a pending write is discarded, not committed.
REQ-032 After reset, DataOutA/B SHALL read 0 for every address.

Structure
REQ-033 Constants REG_W=8 and REG_A=3 SHALL live in package Definitions, alongside the ALU op enum.
REQ-034 The block SHALL be flat with no sub-module; the writeback stage and flag register are inline.
REQ-035 The array SHALL be a single unpacked logic array updated in one clocked block.

Verification
REQ-036 Reset, then read all 8 addresses on both ports -> every read is 0x00, PendValid=0, flags 000.
REQ-037 WrEn with R3=0xA5 at edge N, RaddrA=3 in cycle N+1 -> DataOutA=0xA5 (forwarded, PendValid=1); at N+2 -> 0xA5 from the array, PendValid=0.
REQ-038 Consecutive writes R2=0x11 then R2=0x22, RaddrA=RaddrB=2 -> 0x11 after the first edge, 0x22 after the second, 0x22 stable afterwards.
REQ-039 WrEn R5=0x3C with RaddrB=5 in the same cycle, R5 previously 0x07 -> DataOutB=0x07 that cycle and 0x3C the next.
REQ-040 WrEn R1=0xFF, then Reset=1 on the next edge with WrEn=0 -> R1 reads 0x00 and PendValid=0; the pending write is discarded.
REQ-041 FlagWrEn=1 with Zero/Parity/Odd=1/0/1, then FlagWrEn=0 with inputs 0/1/0 -> outputs 1/0/1 hold until the next FlagWrEn.
